mc_ctrl: RTL and testbench

Multi-cycle main controller for the Microsystem MIPS core. It decodes the instruction held in the instruction register and sequences fetch, decode, execute, memory and writeback one state per clock. It drives the extender's `extop` select, the ALU, register-file, memory and next-PC controls. It sits directly upstream of the immediate extender and the datapath muxes.

---
 rtl/mc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: decodes op/funct and sequences one state per clock.
// Optional feature macro: CTRL_ADDIU_EN (decodes addiu as an I-type ALU instruction).
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcwr,
    output logic       irwr,
    output logic       regwr,
    output logic       memwr,
    output logic [1:0] extop,
    output logic       alusrc,
    output logic [2:0] aluop,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] npcop
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXE    = 4'd2,
        ALUWB  = 4'd3,
        MADDR  = 4'd4,
        MRD    = 4'd5,
        MWB    = 4'd6,
        MWR    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_e;

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       regwr;
        logic       memwr;
        logic       alusrc;
        logic [2:0] aluop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] npcop;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic is_r, r_addu, r_subu, r_jr;
    logic i_ori, i_lw, i_sw, i_beq, i_lui, i_j, i_jal, i_addiu;
    logic [1:0] ext_c;
    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    assign is_r   = (op == OP_RTYPE);
    assign r_addu = is_r && (funct == FN_ADDU);
    assign r_subu = is_r && (funct == FN_SUBU);
    assign r_jr   = is_r && (funct == FN_JR);
    assign i_ori  = (op == OP_ORI);
    assign i_lw   = (op == OP_LW);
    assign i_sw   = (op == OP_SW);
    assign i_beq  = (op == OP_BEQ);
    assign i_lui  = (op == OP_LUI);
    assign i_j    = (op == OP_J);
    assign i_jal  = (op == OP_JAL);
`ifdef CTRL_ADDIU_EN
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    assign i_addiu = (op == OP_ADDIU);
`else
    assign i_addiu = 1'b0;
`endif

    always_comb begin
        ext_c = 2'b00;
        if (i_lw || i_sw || i_beq || i_addiu) ext_c = 2'b01;
        else if (i_lui)                       ext_c = 2'b10;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (r_addu || r_subu || i_ori || i_lui || i_addiu) state_d = EXE;
                else if (i_lw || i_sw)                           state_d = MADDR;
                else if (i_beq)                                  state_d = BRANCH;
                else if (i_j || i_jal || r_jr)                   state_d = JUMP;
                else                                             state_d = FETCH;
            end
            EXE:    state_d = ALUWB;
            MADDR:  state_d = i_lw ? MRD : MWR;
            MRD:    state_d = MWB;
            default: state_d = FETCH;
        endcase
    end

    // Controls are registered from the upcoming state; op/funct are already stable when they matter.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            FETCH: begin
                ctrl_d.pcwr = 1'b1;
                ctrl_d.irwr = 1'b1;
            end
            EXE: begin
                ctrl_d.alusrc = !is_r;
                if (r_subu)     ctrl_d.aluop = 3'b001;
                else if (i_ori) ctrl_d.aluop = 3'b010;
            end
            ALUWB: begin
                ctrl_d.regwr  = 1'b1;
                ctrl_d.regdst = is_r ? 2'b01 : 2'b00;
            end
            MADDR: ctrl_d.alusrc = 1'b1;
            MWB: begin
                ctrl_d.regwr    = 1'b1;
                ctrl_d.memtoreg = 2'b01;
            end
            MWR:    ctrl_d.memwr = 1'b1;
            BRANCH: begin
                ctrl_d.aluop = 3'b001;
                ctrl_d.npcop = 2'b01;
            end
            JUMP: begin
                ctrl_d.pcwr  = 1'b1;
                ctrl_d.npcop = r_jr ? 2'b11 : 2'b10;
                if (i_jal) begin
                    ctrl_d.regwr    = 1'b1;
                    ctrl_d.regdst   = 2'b10;
                    ctrl_d.memtoreg = 2'b10;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            ctrl_q      <= '0;
            ctrl_q.pcwr <= 1'b1;
            ctrl_q.irwr <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Branch PC write follows the live zero flag; reset masks every output immediately.
    assign pcwr     = !reset && (ctrl_q.pcwr || (state_q == BRANCH && zero));
    assign irwr     = !reset && ctrl_q.irwr;
    assign regwr    = !reset && ctrl_q.regwr;
    assign memwr    = !reset && ctrl_q.memwr;
    assign alusrc   = !reset && ctrl_q.alusrc;
    assign aluop    = reset ? 3'b000 : ctrl_q.aluop;
    assign regdst   = reset ? 2'b00 : ctrl_q.regdst;
    assign memtoreg = reset ? 2'b00 : ctrl_q.memtoreg;
    assign npcop    = reset ? 2'b00 : ctrl_q.npcop;
    assign extop    = reset ? 2'b00 : ext_c;
endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl: per-cycle state/output vectors plus per-instruction cycle and enable counts.
module tb_mc_ctrl;
    logic       clk, reset, zero;
    logic [5:0] op, funct;
    logic       pcwr, irwr, regwr, memwr, alusrc;
    logic [1:0] extop, regdst, memtoreg, npcop;
    logic [2:0] aluop;

    int n_cmp = 0;
    int n_bad = 0;
    int n_both = 0;

    localparam logic [5:0] R     = 6'b000000;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] LUI   = 6'b001111;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] JAL   = 6'b000011;
    localparam logic [5:0] ADDIU = 6'b001001;
    localparam logic [5:0] ADDU  = 6'b100001;
    localparam logic [5:0] SUBU  = 6'b100011;
    localparam logic [5:0] JR    = 6'b001000;
    localparam logic [5:0] XX    = 6'b000000;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [3:0] st;
        logic [15:0] outs;
    } vec_t;

    vec_t vecs[$];

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcwr(pcwr), .irwr(irwr), .regwr(regwr), .memwr(memwr),
        .extop(extop), .alusrc(alusrc), .aluop(aluop), .regdst(regdst),
        .memtoreg(memtoreg), .npcop(npcop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (regwr && memwr) n_both++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1);
    end

    // {pcwr,irwr,regwr,memwr,extop,alusrc,aluop,regdst,memtoreg,npcop}
    function automatic logic [15:0] o(input logic pc, input logic ir, input logic rw, input logic mw,
                                     input logic [1:0] ext, input logic src, input logic [2:0] aop,
                                     input logic [1:0] rd, input logic [1:0] m2r, input logic [1:0] npc);
        return {pc, ir, rw, mw, ext, src, aop, rd, m2r, npc};
    endfunction

    function automatic logic [15:0] F(input logic [1:0] ext);
        return o(1'b1, 1'b1, 1'b0, 1'b0, ext, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00);
    endfunction

    function automatic logic [15:0] Z(input logic [1:0] ext);
        return o(1'b0, 1'b0, 1'b0, 1'b0, ext, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00);
    endfunction

    function automatic logic [15:0] act_outs();
        return {pcwr, irwr, regwr, memwr, extop, alusrc, aluop, regdst, memtoreg, npcop};
    endfunction

    task automatic add(input logic r, input logic [5:0] op_v, input logic [5:0] fn_v,
                       input logic z, input logic [3:0] s, input logic [15:0] e);
        vec_t v;
        v.rst = r; v.op = op_v; v.funct = fn_v; v.zero = z; v.st = s; v.outs = e;
        vecs.push_back(v);
    endtask

    task automatic run_instr(input string nm, input logic [5:0] op_v, input logic [5:0] fn_v,
                             input logic z, input int ecyc, input int epc, input int erw, input int emw);
        int cyc, npc, nrw, nmw;
        logic [3:0] s;
        cyc = 0; npc = 0; nrw = 0; nmw = 0;
        op = op_v; funct = fn_v; zero = z;
        for (int k = 0; k < 12; k++) begin
            #1;
            npc += int'(pcwr); nrw += int'(regwr); nmw += int'(memwr);
            cyc++;
            @(posedge clk); #1;
            s = dut.state_q;
            if (s == 4'd0) break;
        end
        n_cmp++;
        if (cyc != ecyc) begin n_bad++; $display("FAIL %s cycles: got %0d, expected %0d", nm, cyc, ecyc); end
        n_cmp++;
        if (npc != epc) begin n_bad++; $display("FAIL %s pcwr count: got %0d, expected %0d", nm, npc, epc); end
        n_cmp++;
        if (nrw != erw) begin n_bad++; $display("FAIL %s regwr count: got %0d, expected %0d", nm, nrw, erw); end
        n_cmp++;
        if (nmw != emw) begin n_bad++; $display("FAIL %s memwr count: got %0d, expected %0d", nm, nmw, emw); end
    endtask

    initial begin
        logic [3:0] st_act;
        logic [15:0] o_act;

        // addu / subu
        add(0, R, ADDU, 0, 4'd0, F(2'b00));
        add(0, R, ADDU, 0, 4'd1, Z(2'b00));
        add(0, R, ADDU, 0, 4'd2, Z(2'b00));
        add(0, R, ADDU, 0, 4'd3, o(0, 0, 1, 0, 2'b00, 0, 3'b000, 2'b01, 2'b00, 2'b00));
        add(0, R, SUBU, 0, 4'd0, F(2'b00));
        add(0, R, SUBU, 0, 4'd1, Z(2'b00));
        add(0, R, SUBU, 0, 4'd2, o(0, 0, 0, 0, 2'b00, 0, 3'b001, 2'b00, 2'b00, 2'b00));
        add(0, R, SUBU, 0, 4'd3, o(0, 0, 1, 0, 2'b00, 0, 3'b000, 2'b01, 2'b00, 2'b00));
        // ori
        add(0, ORI, XX, 0, 4'd0, F(2'b00));
        add(0, ORI, XX, 0, 4'd1, Z(2'b00));
        add(0, ORI, XX, 0, 4'd2, o(0, 0, 0, 0, 2'b00, 1, 3'b010, 2'b00, 2'b00, 2'b00));
        add(0, ORI, XX, 0, 4'd3, o(0, 0, 1, 0, 2'b00, 0, 3'b000, 2'b00, 2'b00, 2'b00));
        // lw, sw
        add(0, LW, XX, 0, 4'd0, F(2'b01));
        add(0, LW, XX, 0, 4'd1, Z(2'b01));
        add(0, LW, XX, 0, 4'd4, o(0, 0, 0, 0, 2'b01, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        add(0, LW, XX, 0, 4'd5, Z(2'b01));
        add(0, LW, XX, 0, 4'd6, o(0, 0, 1, 0, 2'b01, 0, 3'b000, 2'b00, 2'b01, 2'b00));
        add(0, SW, XX, 0, 4'd0, F(2'b01));
        add(0, SW, XX, 0, 4'd1, Z(2'b01));
        add(0, SW, XX, 0, 4'd4, o(0, 0, 0, 0, 2'b01, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        add(0, SW, XX, 0, 4'd7, o(0, 0, 0, 1, 2'b01, 0, 3'b000, 2'b00, 2'b00, 2'b00));
        // beq taken / not taken
        add(0, BEQ, XX, 1, 4'd0, F(2'b01));
        add(0, BEQ, XX, 1, 4'd1, Z(2'b01));
        add(0, BEQ, XX, 1, 4'd8, o(1, 0, 0, 0, 2'b01, 0, 3'b001, 2'b00, 2'b00, 2'b01));
        add(0, BEQ, XX, 0, 4'd0, F(2'b01));
        add(0, BEQ, XX, 0, 4'd1, Z(2'b01));
        add(0, BEQ, XX, 0, 4'd8, o(0, 0, 0, 0, 2'b01, 0, 3'b001, 2'b00, 2'b00, 2'b01));
        // j, jal, jr
        add(0, J, XX, 0, 4'd0, F(2'b00));
        add(0, J, XX, 0, 4'd1, Z(2'b00));
        add(0, J, XX, 0, 4'd9, o(1, 0, 0, 0, 2'b00, 0, 3'b000, 2'b00, 2'b00, 2'b10));
        add(0, JAL, XX, 0, 4'd0, F(2'b00));
        add(0, JAL, XX, 0, 4'd1, Z(2'b00));
        add(0, JAL, XX, 0, 4'd9, o(1, 0, 1, 0, 2'b00, 0, 3'b000, 2'b10, 2'b10, 2'b10));
        add(0, R, JR, 0, 4'd0, F(2'b00));
        add(0, R, JR, 0, 4'd1, Z(2'b00));
        add(0, R, JR, 0, 4'd9, o(1, 0, 0, 0, 2'b00, 0, 3'b000, 2'b00, 2'b00, 2'b11));
        // lui
        add(0, LUI, XX, 0, 4'd0, F(2'b10));
        add(0, LUI, XX, 0, 4'd1, Z(2'b10));
        add(0, LUI, XX, 0, 4'd2, o(0, 0, 0, 0, 2'b10, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        add(0, LUI, XX, 0, 4'd3, o(0, 0, 1, 0, 2'b10, 0, 3'b000, 2'b00, 2'b00, 2'b00));
        // op 001001
`ifdef CTRL_ADDIU_EN
        add(0, ADDIU, XX, 0, 4'd0, F(2'b01));
        add(0, ADDIU, XX, 0, 4'd1, Z(2'b01));
        add(0, ADDIU, XX, 0, 4'd2, o(0, 0, 0, 0, 2'b01, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        add(0, ADDIU, XX, 0, 4'd3, o(0, 0, 1, 0, 2'b01, 0, 3'b000, 2'b00, 2'b00, 2'b00));
`else
        add(0, ADDIU, XX, 0, 4'd0, F(2'b00));
        add(0, ADDIU, XX, 0, 4'd1, Z(2'b00));
`endif
        // illegal funct, illegal op
        add(0, R, 6'b111111, 0, 4'd0, F(2'b00));
        add(0, R, 6'b111111, 0, 4'd1, Z(2'b00));
        add(0, 6'b111111, XX, 0, 4'd0, F(2'b00));
        add(0, 6'b111111, XX, 0, 4'd1, Z(2'b00));
        // reset held 3 cycles starting in MWR of a sw, then a complete sw
        add(0, SW, XX, 0, 4'd0, F(2'b01));
        add(0, SW, XX, 0, 4'd1, Z(2'b01));
        add(0, SW, XX, 0, 4'd4, o(0, 0, 0, 0, 2'b01, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        add(1, SW, XX, 0, 4'd7, 16'h0000);
        add(1, SW, XX, 0, 4'd0, 16'h0000);
        add(1, SW, XX, 0, 4'd0, 16'h0000);
        add(0, SW, XX, 0, 4'd0, F(2'b01));
        add(0, SW, XX, 0, 4'd1, Z(2'b01));
        add(0, SW, XX, 0, 4'd4, o(0, 0, 0, 0, 2'b01, 1, 3'b000, 2'b00, 2'b00, 2'b00));
        add(0, SW, XX, 0, 4'd7, o(0, 0, 0, 1, 2'b01, 0, 3'b000, 2'b00, 2'b00, 2'b00));
        // reset during EXE of ori abandons it
        add(0, ORI, XX, 0, 4'd0, F(2'b00));
        add(0, ORI, XX, 0, 4'd1, Z(2'b00));
        add(1, ORI, XX, 0, 4'd2, 16'h0000);
        add(0, ORI, XX, 0, 4'd0, F(2'b00));

        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        st_act = dut.state_q;
        n_cmp++;
        if (st_act != 4'd0) begin n_bad++; $display("FAIL reset state: got %0d, expected 0", st_act); end
        o_act = act_outs();
        n_cmp++;
        if (o_act != 16'h0000) begin n_bad++; $display("FAIL reset outputs: got %h, expected 0000", o_act); end

        foreach (vecs[i]) begin
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
            #1;
            st_act = dut.state_q;
            o_act = act_outs();
            n_cmp++;
            if (st_act !== vecs[i].st || o_act !== vecs[i].outs) begin
                n_bad++;
                $display("FAIL vec%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                         i, st_act, o_act, vecs[i].st, vecs[i].outs);
            end
            @(posedge clk); #1;
        end

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr("addu", R, ADDU, 1'b0, 4, 1, 1, 0);
        run_instr("lw", LW, XX, 1'b0, 5, 1, 1, 0);
        run_instr("sw", SW, XX, 1'b0, 4, 1, 0, 1);
        run_instr("beq_t", BEQ, XX, 1'b1, 3, 2, 0, 0);
        run_instr("beq_nt", BEQ, XX, 1'b0, 3, 1, 0, 0);
        run_instr("jal", JAL, XX, 1'b0, 3, 2, 1, 0);
        run_instr("jr", R, JR, 1'b0, 3, 2, 0, 0);
        run_instr("illegal", 6'b110000, XX, 1'b0, 2, 1, 0, 0);
`ifdef CTRL_ADDIU_EN
        run_instr("addiu", ADDIU, XX, 1'b0, 4, 1, 1, 0);
`else
        run_instr("addiu", ADDIU, XX, 1'b0, 2, 1, 0, 0);
`endif

        n_cmp++;
        if (n_both != 0) begin n_bad++; $display("FAIL regwr_memwr_exclusive: got %0d overlap cycles, expected 0", n_both); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
